// File: rtl/display_scan.sv
// rtl/display_scan.sv - six-digit multiplexed seven-segment scanner with frame snapshot and field blink
module display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic [1:0] set_sel,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [23:0]   snap_q, snap_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       scan_wrap, blink_wrap, blank;
  logic [3:0] nib;
  logic [1:0] field;
  logic [6:0] dec;

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    if (scan_wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = blink_on_q ^ blink_wrap;
    // One snapshot per frame, taken during slot 0's blank window so no frame tears.
    snap_d      = (idx_q == 3'd0 && scan_cnt_q == '0) ? {hour_bcd, min_bcd, sec_bcd} : snap_q;
  end

  always_comb begin
    nib   = 4'd0;
    field = 2'b00;
    case (idx_q)
      3'd0: begin nib = snap_q[3:0];   field = 2'b11; end
      3'd1: begin nib = snap_q[7:4];   field = 2'b11; end
      3'd2: begin nib = snap_q[11:8];  field = 2'b10; end
      3'd3: begin nib = snap_q[15:12]; field = 2'b10; end
      3'd4: begin nib = snap_q[19:16]; field = 2'b01; end
      3'd5: begin nib = snap_q[23:20]; field = 2'b01; end
      default: begin nib = 4'd0; field = 2'b00; end
    endcase
    case (nib)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
    blank = (scan_cnt_q < BLANK_END) ||
            (!blink_on_q && set_sel != 2'b00 && set_sel == field);
    an_d  = blank ? 6'h3F : ~(6'd1 << idx_q);
    seg_d = blank ? 7'h7F : dec;
    dp_d  = blank ? 1'b1 : !(idx_q == 3'd2 || idx_q == 3'd4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      snap_q      <= 24'd0;
      an_q        <= 6'h3F;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed six-digit seven-segment driver for the digital clock; it sits directly downstream of the hour, minute and second control counters. Each frame it snapshots the packed-BCD hours, minutes and seconds values and scans them onto a common-anode display. The separator point is lit after the hour and minute fields. The field currently being set blinks.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ 4.
- BLANK_CYC, 2: anti-ghosting cycles at the start of each slot with all anodes off; range 1 ≤ BLANK_CYC < SCAN_DIV.
- BLINK_DIV, 12500000: clock cycles per blink half-period; must be ≥ 2.

Ports:
- clk, input, 1: system clock; all state is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- hour_bcd, input, 8: hours as BCD {tens, ones}, from the hour control.
- min_bcd, input, 8: minutes as BCD {tens, ones}.
- sec_bcd, input, 8: seconds as BCD {tens, ones}.
- set_sel, input, 2: field that blinks; 00 none, 01 hours, 10 minutes, 11 seconds.
- an, output, 6: anode enables, active-low; an[0] is the rightmost digit (seconds ones) and an[5] is hours tens.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low.

## Operation
- Counters:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - At wrap, idx advances 0→1→…→5→0.
  - blink_cnt counts 0..BLINK_DIV-1; at its wrap, blink_on toggles.
- Snapshot:
  - A 24-bit register loads {hour_bcd, min_bcd, sec_bcd} on every cycle where idx==0 and scan_cnt==0, including the first cycle after reset release.
  - All six digits of a frame are taken from the same snapshot. Input changes mid-frame never tear a frame.
- Digit mapping, by idx: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hour ones, 5 = hour tens.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble 10–15 decodes to 0111111 (dash: segment g only).
- Slot output:
  - While scan_cnt < BLANK_CYC: an=111111, seg=1111111, dp=1.
  - Otherwise: an has only bit idx low, seg is the decoded digit, and dp=0 when idx is 2 or 4, else 1.
- Blink suppression: when blink_on==0 and set_sel selects the field containing idx, the whole slot is treated as blank. Fields: 01 covers idx 4–5, 10 covers idx 2–3, 11 covers idx 0–1.
- set_sel is not snapshotted; a change takes effect with the normal one-cycle output latency.

## Timing
- an, seg and dp are registered.
- Outputs in cycle t+1 reflect scan_cnt, idx, snapshot, set_sel and blink_on as they stand in cycle t. The snapshot loaded in the idx 0 blank window is therefore visible in slot 0.
- Reset values, applied immediately on reset assertion without waiting for a clock edge:
  - an=111111, seg=1111111, dp=1.
  - scan_cnt=0, idx=0, blink_cnt=0, blink_on=1.
  - snapshot=0.
- After reset release, the first lit anode is an[0], first visible in output cycle BLANK_CYC+1.
- Frame period is 6·SCAN_DIV cycles.
- Each digit is lit for SCAN_DIV−BLANK_CYC consecutive cycles.
- Reset mid-slot blanks the display and restarts the scan at idx 0.
- Blink phase changes are not aligned to slots; a phase change mid-slot blanks or unblanks the digit from the next output cycle.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64.
- Reset: assert reset asynchronously mid-slot → an=111111, seg=1111111, dp=1 immediately; after release, an=111110 first appears in output cycle 3.
- Frame content: hour=0x23, min=0x59, sec=0x07, set_sel=00 → over one frame seg per slot is 1111000, 1000000, 0010000, 0010010, 0110000, 0100100. dp=0 only while an[2] or an[4] is low. Each slot has 2 blank cycles followed by 6 lit cycles.
- Snapshot integrity: set sec=0x07 and change it to 0x18 while idx==1 → the rest of that frame still shows 07; the next frame shows slot 0 = 0000000 and slot 1 = 1111001.
- Blink: set_sel=01 → during the blink_on=0 half-periods (64 cycles each), an[5] and an[4] stay high and seg/dp stay blank; slots 0–3 are unaffected. Switching to set_sel=00 restores the hour digits in the next lit cycle.
- Invalid BCD: min_bcd=0xAF → slots 2 and 3 show seg=0111111.
- Wrap and continuity: run 3 frames → idx goes 5→0 without a gap, and exactly one anode is low in every non-blank cycle.
